dram_rddata_stage: RTL and testbench

- Read-return staging buffer directly downstream of the DDR repeater's pad-to-controller path (io_dram_*_buf).
- Registers each 256b data + 32b ECC beat from the pads and tags it with its beat index within a 64B line (2 beats).
- Buffers beats in a small FIFO and presents them to the DRAM controller read path over a valid/ready handshake.
- The pads cannot be stalled, so overflow is detected and reported, never back-pressured.

---
 rtl/dram_rd_pkg.sv | 18 +
 rtl/dram_rd_fifo.sv | 77 +++++++
 rtl/dram_rddata_stage.sv | 91 +++++++++
 tb/tb_dram_rddata_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_rd_pkg.sv
// Shared constants and beat record for the DRAM read-return staging path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dram_rd_pkg;

    localparam int DRAM_RD_DATA_W = 256;
    localparam int DRAM_RD_ECC_W  = 32;
    localparam int DRAM_RD_BEATS  = 2;
    localparam int DRAM_RD_BEAT_W = $clog2(DRAM_RD_BEATS);

    // One staged read-return beat: payload, its ECC and its index within the line
    typedef struct packed {
        logic [DRAM_RD_DATA_W-1:0] data;
        logic [DRAM_RD_ECC_W-1:0]  ecc;
        logic [DRAM_RD_BEAT_W-1:0] beat;
    } dram_rd_beat_t;

endpackage

// File: rtl/dram_rd_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count and synchronous flush.
// Latency: a push at edge E is visible at the head after E (no same-cycle bypass).
// Backpressure: never stalls the writer; a push into a full FIFO without a pop is refused and flagged on o_drop.
module dram_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     arst_l,
    input  logic                     i_flush,
    input  logic                     i_push_vld,
    input  logic [WIDTH-1:0]         i_push_dat,
    output logic                     o_drop,
    output logic                     o_pop_vld,
    input  logic                     i_pop_rdy,
    output logic [WIDTH-1:0]         o_pop_dat,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_pop   = i_pop_rdy && !w_empty;
    // When full, a push only lands if the head leaves in the same cycle
    assign w_wr    = i_push_vld && (!w_full || w_pop);
    assign o_drop  = i_push_vld && w_full && !w_pop && !i_flush;

    assign o_pop_vld = !w_empty;
    // Head is forced to zero when empty so the outputs are clean out of reset
    assign o_pop_dat = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_cnt     = r_cnt;

    // Storage array: written on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers and occupancy; flush discards everything including a same-cycle push/pop
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_wr && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_wr && w_pop) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dram_rddata_stage.sv
// Registers pad read-return beats, tags each with its line beat index and stages them in a FWFT FIFO.
// Latency: 2 cycles from a pad beat sampled at E0 to rd_vld high after E1.
// Backpressure: the pads cannot stall; beats arriving at a full FIFO with no pop are dropped and set sticky rd_ovfl.
module dram_rddata_stage
    import dram_rd_pkg::*;
#(
    parameter int DATA_W = DRAM_RD_DATA_W,
    parameter int ECC_W  = DRAM_RD_ECC_W,
    parameter int DEPTH  = 4,
    parameter int BEATS  = DRAM_RD_BEATS
) (
    input  logic                        clk,
    input  logic                        arst_l,
    input  logic                        io_dram_data_valid_buf,
    input  logic [DATA_W-1:0]           io_dram_data_in_buf,
    input  logic [ECC_W-1:0]            io_dram_ecc_in_buf,
    input  logic                        dram_io_channel_disabled_buf,
    output logic                        rd_vld,
    input  logic                        rd_rdy,
    output logic [DATA_W-1:0]           rd_data,
    output logic [ECC_W-1:0]            rd_ecc,
    output logic [$clog2(BEATS)-1:0]    rd_beat,
    output logic                        rd_last,
    output logic [$clog2(DEPTH):0]      rd_cnt,
    output logic                        rd_ovfl,
    input  logic                        rd_ovfl_clr
);

    localparam int BEAT_W  = $clog2(BEATS);
    localparam int ENTRY_W = DATA_W + ECC_W + BEAT_W;

    logic                r_in_vld;
    logic [ENTRY_W-1:0]  r_in_dat;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_ovfl;

    logic                w_drop;
    logic [ENTRY_W-1:0]  w_head;

    // Input register and beat counter; the counter follows the pad stream even if the beat is later dropped
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_in_vld   <= 1'b0;
            r_in_dat   <= '0;
            r_beat_cnt <= '0;
        end else if (dram_io_channel_disabled_buf) begin
            r_in_vld   <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_in_vld <= io_dram_data_valid_buf;
            r_in_dat <= {io_dram_data_in_buf, io_dram_ecc_in_buf, r_beat_cnt};
            if (io_dram_data_valid_buf) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            r_ovfl <= 1'b0;
        end else if (w_drop) begin
            r_ovfl <= 1'b1;
        end else if (rd_ovfl_clr) begin
            r_ovfl <= 1'b0;
        end
    end

    dram_rd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .arst_l     (arst_l),
        .i_flush    (dram_io_channel_disabled_buf),
        .i_push_vld (r_in_vld),
        .i_push_dat (r_in_dat),
        .o_drop     (w_drop),
        .o_pop_vld  (rd_vld),
        .i_pop_rdy  (rd_rdy),
        .o_pop_dat  (w_head),
        .o_cnt      (rd_cnt)
    );

    assign rd_data = w_head[ENTRY_W-1 -: DATA_W];
    assign rd_ecc  = w_head[BEAT_W +: ECC_W];
    assign rd_beat = w_head[BEAT_W-1:0];
    assign rd_last = rd_vld && (rd_beat == BEAT_W'(BEATS - 1));
    assign rd_ovfl = r_ovfl;

endmodule

// File: tb/tb_dram_rddata_stage.sv
`timescale 1ns/1ps
module tb_dram_rddata_stage;
    import dram_rd_pkg::*;

    localparam int DEPTH = 4;
    localparam int BEATS = DRAM_RD_BEATS;
    localparam int DW    = DRAM_RD_DATA_W;
    localparam int EW    = DRAM_RD_ECC_W;
    localparam int BW    = $clog2(BEATS);

    logic                   clk = 1'b0;
    logic                   arst_l = 1'b0;
    logic                   io_dram_data_valid_buf = 1'b0;
    logic [DW-1:0]          io_dram_data_in_buf = '0;
    logic [EW-1:0]          io_dram_ecc_in_buf = '0;
    logic                   dram_io_channel_disabled_buf = 1'b0;
    logic                   rd_vld;
    logic                   rd_rdy = 1'b0;
    logic [DW-1:0]          rd_data;
    logic [EW-1:0]          rd_ecc;
    logic [BW-1:0]          rd_beat;
    logic                   rd_last;
    logic [$clog2(DEPTH):0] rd_cnt;
    logic                   rd_ovfl;
    logic                   rd_ovfl_clr = 1'b0;

    dram_rddata_stage #(
        .DATA_W (DW),
        .ECC_W  (EW),
        .DEPTH  (DEPTH),
        .BEATS  (BEATS)
    ) dut (
        .clk                          (clk),
        .arst_l                       (arst_l),
        .io_dram_data_valid_buf       (io_dram_data_valid_buf),
        .io_dram_data_in_buf          (io_dram_data_in_buf),
        .io_dram_ecc_in_buf           (io_dram_ecc_in_buf),
        .dram_io_channel_disabled_buf (dram_io_channel_disabled_buf),
        .rd_vld                       (rd_vld),
        .rd_rdy                       (rd_rdy),
        .rd_data                      (rd_data),
        .rd_ecc                       (rd_ecc),
        .rd_beat                      (rd_beat),
        .rd_last                      (rd_last),
        .rd_cnt                       (rd_cnt),
        .rd_ovfl                      (rd_ovfl),
        .rd_ovfl_clr                  (rd_ovfl_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: beats expected at the output, in order, plus line-level bookkeeping
    dram_rd_beat_t exp_q[$];
    int            mdl_cnt  = 0;
    bit            mdl_ovfl = 1'b0;
    bit            pend_vld = 1'b0;
    dram_rd_beat_t pend;
    int            mdl_beat = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: a beat shows up one edge after the pads, joins the queue if there is room
    // (or the head leaves at the same edge), otherwise it is lost and the overflow flag raised.
    initial begin : model
        bit pop;
        bit lost;
        forever begin
            @(posedge clk or negedge arst_l);
            if (!arst_l) begin
                mdl_cnt  = 0;
                mdl_ovfl = 1'b0;
                pend_vld = 1'b0;
                mdl_beat = 0;
                exp_q.delete();
            end else begin
                pop  = (mdl_cnt > 0) && rd_rdy;
                lost = 1'b0;
                if (dram_io_channel_disabled_buf) begin
                    mdl_cnt  = 0;
                    pend_vld = 1'b0;
                    mdl_beat = 0;
                    exp_q.delete();
                end else begin
                    if (pend_vld) begin
                        if (mdl_cnt < DEPTH || pop) begin
                            exp_q.push_back(pend);
                            if (!pop) mdl_cnt = mdl_cnt + 1;
                        end else begin
                            lost = 1'b1;
                        end
                    end else if (pop) begin
                        mdl_cnt = mdl_cnt - 1;
                    end
                    pend_vld   = io_dram_data_valid_buf;
                    pend.data  = io_dram_data_in_buf;
                    pend.ecc   = io_dram_ecc_in_buf;
                    pend.beat  = BW'(mdl_beat);
                    if (io_dram_data_valid_buf) mdl_beat = (mdl_beat + 1) % BEATS;
                end
                if (lost) mdl_ovfl = 1'b1;
                else if (rd_ovfl_clr) mdl_ovfl = 1'b0;
            end
        end
    end

    // Monitor: mid-cycle, compare status against the model and the head against the scoreboard front
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (arst_l) begin
                chk("cnt", 256'(rd_cnt), 256'(mdl_cnt));
                chk("vld", 256'(rd_vld), 256'(mdl_cnt != 0));
                chk("ovfl", 256'(rd_ovfl), 256'(mdl_ovfl));
                if (rd_vld) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat actual=data %0h required=no entry", rd_data);
                    end else begin
                        chk("data", 256'(rd_data), 256'(exp_q[0].data));
                        chk("ecc",  256'(rd_ecc),  256'(exp_q[0].ecc));
                        chk("beat", 256'(rd_beat), 256'(exp_q[0].beat));
                        chk("last", 256'(rd_last), 256'(exp_q[0].beat == BW'(BEATS - 1)));
                        if (rd_rdy) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    // One cycle of stimulus: drive just after the edge, then wait for the next edge
    task automatic step(input bit v, input bit rdy, input bit clr = 1'b0, input bit fl = 1'b0);
        io_dram_data_valid_buf       = v;
        rd_rdy                       = rdy;
        rd_ovfl_clr                  = clr;
        dram_io_channel_disabled_buf = fl;
        for (int i = 0; i < DW / 32; i++) io_dram_data_in_buf[i*32 +: 32] = $urandom();
        io_dram_ecc_in_buf = EW'($urandom());
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_vld"},  256'(rd_vld), 256'(0));
        chk({tag, "_data"}, 256'(rd_data), 256'(0));
        chk({tag, "_ecc"},  256'(rd_ecc), 256'(0));
        chk({tag, "_beat"}, 256'(rd_beat), 256'(0));
        chk({tag, "_last"}, 256'(rd_last), 256'(0));
        chk({tag, "_cnt"},  256'(rd_cnt), 256'(0));
        chk({tag, "_ovfl"}, 256'(rd_ovfl), 256'(0));
    endtask

    initial begin : stim
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        arst_l = 1'b1;
        step(0, 1);

        // Single line with a ready consumer
        step(1, 1);
        step(1, 1);
        repeat (4) step(0, 1);

        // Backpressure: four beats held, then drained
        repeat (4) step(1, 0);
        repeat (3) step(0, 0);
        repeat (6) step(0, 1);

        // Overflow: fifth beat lost, one pop, then one more beat, then clear
        repeat (5) step(1, 0);
        repeat (2) step(0, 0);
        step(0, 1);
        step(1, 0);
        repeat (3) step(0, 0);
        step(0, 0, 1);
        repeat (6) step(0, 1);

        // Full with simultaneous push and pop
        repeat (4) step(1, 0);
        step(0, 0);
        repeat (10) step(1, 1);
        repeat (6) step(0, 1);

        // Flush with overflow already flagged and a partial line in flight
        repeat (5) step(1, 0);
        repeat (2) step(0, 0);
        step(0, 1);
        step(0, 0);
        step(1, 0, 0, 1);
        step(1, 1);
        step(1, 1);
        repeat (4) step(0, 1);
        step(0, 1, 1);

        // Randomised traffic with occasional clears and flushes
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2);
        end

        // Asynchronous reset in the middle of a burst, between edges
        repeat (3) step(1, 0);
        step(1, 0);
        #2;
        arst_l = 1'b0;
        #1;
        chk_zero_outputs("arst");
        io_dram_data_valid_buf = 1'b0;
        @(posedge clk);
        #1;
        arst_l = 1'b1;
        step(1, 1);
        step(1, 1);
        step(1, 1);
        repeat (8) step(0, 1);

        chk("drain", 256'(exp_q.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
